timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped down-counter on the CPU data bus, downstream of the pipeline's memory stage.
- It consumes the same address, write-data and byte-enable signals the CPU presents to data memory, and returns read data.
- The bus bridge decodes the device base address and asserts sel; this block sees only the word offset.
- It asserts an interrupt request when the count expires, in one-shot or periodic mode.

Parameters:
- DW, 32, data/register width; only 32 is supported.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sel  in  1  bridge decode hit for this device
- addr  in  2  word offset, taken from m_data_addr[3:2]
- byteen  in  4  byte write enables, taken from m_data_byteen; a write occurs when any bit is set and sel=1
- wdata  in  32  CPU store data, already lane-shifted
- rdata  out  32  read data (combinational)
- irq  out  1  interrupt request

Behaviour:
- Register map:
  - offset 0 = CTRL: bit0 EN, bits2:1 MODE, bit3 IM; other bits read 0.
  - offset 1 = PRESET: read/write.
  - offset 2 = COUNT: read-only; writes are ignored.
  - offset 3 reads 0.
- Writes: a byte-merged update at the clock edge; each byteen[i] replaces bits [8i+7:8i] only. CTRL keeps bits [3:0] only.
- Reads: rdata = selected register, combinational, regardless of sel.
- Reset (synchronous):
  - CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0.
  - Outputs: irq=0, and rdata reflects the zeroed registers.
- FSM, one transition per clock:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE with COUNT held.
    - Else if COUNT>1, COUNT<=COUNT-1.
    - Else COUNT<=0, irq_flag<=1, go to INT.
  - INT:
    - MODE=00 (one-shot): EN<=0, irq_flag stays 1, go to IDLE.
    - MODE=01 (periodic): irq_flag<=0, go to IDLE; EN is still 1, so the counter reloads.
    - MODE=1x: treated as 00.
- irq = irq_flag & IM.
- irq_flag is also cleared by any write to CTRL or PRESET.
- Timing: EN written at edge t gives LOAD at t+1 and CNT with COUNT=N at t+2. COUNT=1 is reached at t+N+1. INT, COUNT=0 and irq high follow at t+N+2.
- Periodic mode: one-cycle irq pulse every N+3 cycles.
- PRESET=0 or 1: COUNT loads that value; INT is reached one cycle after entering CNT.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as the INT-state EN clear: the CPU write wins.
  - A CPU write to PRESET during CNT does not affect the current count; it takes effect at the next LOAD.
  - Clearing EN mid-count freezes COUNT. Re-enabling goes through LOAD and reloads PRESET.
- COUNT never wraps below 0.
- Reset asserted mid-count returns everything to reset values at that edge.

Decomposition:
- Shared package contains:
  - state encoding: IDLE, LOAD, CNT, INT (2 bits);
  - register offsets: CTRL=0, PRESET=1, COUNT=2;
  - CTRL bit positions and mode codes;
  - a byte-merge function (old, new, byteen) reusable by the data-memory model.
- No sub-module is needed; a single module with one FSM always-block and a register write block.

Test Plan:
- Reset held 2 cycles, then released -> rdata=0 at all offsets, irq=0.
- Write PRESET=5, then CTRL=0x9 (EN, mode0, IM) -> COUNT reads 5,4,3,2,1,0 on successive cycles from t+2. irq rises at t+7 and stays high. CTRL reads 0x8.
- Same sequence with CTRL=0xB (mode1) -> irq pulses for 1 cycle at t+7, t+15, t+23 (period 8).
- Write PRESET=0x12345678 with byteen=0100, then read -> 0x00340000. A write to COUNT is ignored (reads unchanged).
- Mid-count at COUNT=3, write CTRL=0x8 -> COUNT frozen at 3. Re-write CTRL=0x9 -> LOAD, then COUNT=PRESET.
- irq high in mode0, then write PRESET -> irq low the next cycle. Assert reset during CNT -> COUNT=0, state IDLE next cycle.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counter: FSM encoding,
// register offsets, CTRL field positions and the bus byte-merge helper.
package timer_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    // Replace only the byte lanes whose enable is set; also used by the data-memory model.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  byteen);
        logic [31:0] merged_s;
        merged_s = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                merged_s[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged_s;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counter with one-shot / periodic modes and a maskable
// interrupt; sits on the CPU data bus behind the bridge decode (sel).
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sel,
    input  logic [1:0]    addr,
    input  logic [3:0]    byteen,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          irq
);

    state_t        state_r, state_nx_s;
    logic [3:0]    ctrl_r, ctrl_nx_s;
    logic [DW-1:0] preset_r, preset_nx_s;
    logic [DW-1:0] count_r, count_nx_s;
    logic          irq_flag_r, irq_flag_nx_s;
    logic          irq_r;
    logic          wr_ctrl_s, wr_preset_s;
    logic          irq_set_s, irq_clr_fsm_s, en_clr_s;
    logic [1:0]    mode_s;

    assign wr_ctrl_s   = sel && (|byteen) && (addr == OFF_CTRL);
    assign wr_preset_s = sel && (|byteen) && (addr == OFF_PRESET);
    assign mode_s      = ctrl_r[CTRL_MODE_HI:CTRL_MODE_LO];

    // Counter FSM: next state, next count and interrupt events.
    always_comb begin
        state_nx_s    = state_r;
        count_nx_s    = count_r;
        irq_set_s     = 1'b0;
        irq_clr_fsm_s = 1'b0;
        en_clr_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_r[CTRL_EN]) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_nx_s = preset_r;
                state_nx_s = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_r[CTRL_EN]) begin
                    state_nx_s = ST_IDLE;
                end else if (count_r > 32'd1) begin
                    count_nx_s = count_r - 32'd1;
                end else begin
                    // Saturate at zero so PRESET of 0 or 1 still expires cleanly.
                    count_nx_s = 32'd0;
                    irq_set_s  = 1'b1;
                    state_nx_s = ST_INT;
                end
            end
            ST_INT: begin
                if (mode_s == MODE_PERIODIC) begin
                    irq_clr_fsm_s = 1'b1;
                end else begin
                    en_clr_s = 1'b1;
                end
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Register-file next values; a CPU CTRL write overrides the one-shot EN clear.
    always_comb begin
        ctrl_nx_s   = ctrl_r;
        preset_nx_s = preset_r;
        if (wr_ctrl_s) begin
            if (byteen[0]) begin
                ctrl_nx_s = wdata[3:0];
            end else begin
                ctrl_nx_s = ctrl_r;
            end
        end else if (en_clr_s) begin
            ctrl_nx_s[CTRL_EN] = 1'b0;
        end else begin
            ctrl_nx_s = ctrl_r;
        end
        if (wr_preset_s) begin
            preset_nx_s = byte_merge(preset_r, wdata, byteen);
        end else begin
            preset_nx_s = preset_r;
        end
    end

    // Interrupt flag: expiry sets it, periodic wrap or software write clears it.
    always_comb begin
        if (irq_set_s) begin
            irq_flag_nx_s = 1'b1;
        end else if (irq_clr_fsm_s || wr_ctrl_s || wr_preset_s) begin
            irq_flag_nx_s = 1'b0;
        end else begin
            irq_flag_nx_s = irq_flag_r;
        end
    end

    // State, count, flag and registered interrupt output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            count_r    <= 32'd0;
            irq_flag_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            count_r    <= count_nx_s;
            irq_flag_r <= irq_flag_nx_s;
            irq_r      <= irq_flag_nx_s & ctrl_nx_s[CTRL_IM];
        end
    end

    // CPU-visible register write block.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r   <= 4'd0;
            preset_r <= 32'd0;
        end else begin
            ctrl_r   <= ctrl_nx_s;
            preset_r <= preset_nx_s;
        end
    end

    // Combinational read mux, independent of sel.
    always_comb begin
        case (addr)
            OFF_CTRL:   rdata = {28'd0, ctrl_r};
            OFF_PRESET: rdata = preset_r;
            OFF_COUNT:  rdata = count_r;
            default:    rdata = 32'd0;
        endcase
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: the driver queues expected {irq, rdata}
// per read cycle and a negedge monitor pops and compares.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    timer_counter #(.DW(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    // Monitor: one expected response per read cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [32:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if ({irq, rdata} !== e) begin
                errors++;
                $display("FAIL %s: got irq=%0b rdata=0x%08h, expected irq=%0b rdata=0x%08h",
                         n, irq, rdata, e[32], e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        sel    = 1'b1;
        addr   = a;
        wdata  = d;
        byteen = be;
        tick();
        sel    = 1'b0;
        byteen = 4'b0000;
    endtask

    task automatic chk(input string n, input logic [1:0] a, input logic [31:0] d, input logic i);
        addr = a;
        exp_q.push_back({i, d});
        name_q.push_back(n);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        sel    = 1'b0;
        addr   = 2'd0;
        byteen = 4'b0000;
        wdata  = 32'd0;
        do_reset();
        for (int a = 0; a < 4; a++) chk("reset_read", a[1:0], 32'd0, 1'b0);

        // One-shot, PRESET=5: COUNT 5..0 from t+2, irq from t+7 held.
        wr(2'd1, 32'd5, 4'b1111);
        wr(2'd0, 32'h9, 4'b1111);
        for (int k = 0; k <= 8; k++)
            chk("oneshot_count", 2'd2, (k >= 2 && k <= 7) ? 32'(7 - k) : 32'd0, (k >= 7));
        chk("oneshot_ctrl_en_cleared", 2'd0, 32'h8, 1'b1);

        // Periodic, PRESET=5: 1-cycle irq every 8 cycles.
        do_reset();
        wr(2'd1, 32'd5, 4'b1111);
        wr(2'd0, 32'hB, 4'b1111);
        for (int k = 0; k <= 24; k++) begin
            int j;
            j = k % 8;
            chk("periodic_count_irq", 2'd2, (j >= 2) ? 32'(7 - j) : 32'd0, (j == 7));
        end

        // Byte merge, read-only COUNT, CTRL masking, offset 3.
        do_reset();
        wr(2'd1, 32'h12345678, 4'b0100);
        chk("preset_byte2", 2'd1, 32'h00340000, 1'b0);
        wr(2'd1, 32'hAABBCCDD, 4'b0011);
        chk("preset_byte10", 2'd1, 32'h0034CCDD, 1'b0);
        wr(2'd2, 32'hFFFFFFFF, 4'b1111);
        chk("count_readonly", 2'd2, 32'd0, 1'b0);
        wr(2'd0, 32'h000000FC, 4'b0001);
        chk("ctrl_mask", 2'd0, 32'hC, 1'b0);
        chk("offset3_zero", 2'd3, 32'd0, 1'b0);

        // Freeze at COUNT=3 by clearing EN, then re-enable reloads PRESET.
        do_reset();
        wr(2'd1, 32'd6, 4'b1111);
        wr(2'd0, 32'h9, 4'b1111);
        chk("freeze_pre", 2'd2, 32'd0, 1'b0);
        chk("freeze_pre", 2'd2, 32'd0, 1'b0);
        chk("freeze_pre", 2'd2, 32'd6, 1'b0);
        chk("freeze_pre", 2'd2, 32'd5, 1'b0);
        wr(2'd0, 32'h8, 4'b1111);
        for (int k = 0; k < 4; k++) chk("freeze_hold", 2'd2, 32'd3, 1'b0);
        wr(2'd0, 32'h9, 4'b1111);
        chk("reenable_idle", 2'd2, 32'd3, 1'b0);
        chk("reenable_load", 2'd2, 32'd3, 1'b0);
        chk("reenable_reload", 2'd2, 32'd6, 1'b0);
        chk("reenable_dec", 2'd2, 32'd5, 1'b0);

        // PRESET=1 expiry, then PRESET write clears irq.
        do_reset();
        wr(2'd1, 32'd1, 4'b1111);
        wr(2'd0, 32'h9, 4'b1111);
        chk("p1_idle", 2'd2, 32'd0, 1'b0);
        chk("p1_load", 2'd2, 32'd0, 1'b0);
        chk("p1_cnt", 2'd2, 32'd1, 1'b0);
        chk("p1_int", 2'd2, 32'd0, 1'b1);
        chk("p1_hold", 2'd2, 32'd0, 1'b1);
        chk("p1_ctrl", 2'd0, 32'h8, 1'b1);
        wr(2'd1, 32'h20, 4'b1111);
        chk("irq_cleared_by_preset", 2'd2, 32'd0, 1'b0);

        // PRESET=0 expiry, no wrap below zero.
        wr(2'd1, 32'd0, 4'b1111);
        wr(2'd0, 32'h9, 4'b1111);
        chk("p0_idle", 2'd2, 32'd0, 1'b0);
        chk("p0_load", 2'd2, 32'd0, 1'b0);
        chk("p0_cnt", 2'd2, 32'd0, 1'b0);
        chk("p0_int", 2'd2, 32'd0, 1'b1);
        chk("p0_hold", 2'd2, 32'd0, 1'b1);

        // Reset during CNT.
        wr(2'd1, 32'd10, 4'b1111);
        wr(2'd0, 32'h9, 4'b1111);
        chk("rst_pre", 2'd2, 32'd0, 1'b0);
        chk("rst_pre", 2'd2, 32'd0, 1'b0);
        chk("rst_pre", 2'd2, 32'd10, 1'b0);
        chk("rst_pre", 2'd2, 32'd9, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_count", 2'd2, 32'd0, 1'b0);
        chk("rst_ctrl", 2'd0, 32'd0, 1'b0);
        chk("rst_preset", 2'd1, 32'd0, 1'b0);
        chk("rst_idle_count", 2'd2, 32'd0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
